u712_buffer_sequencer: RTL and testbench
========================================

# u712_buffer_sequencer

Registered, parametrised successor to the U712 chip-set buffer control logic. It drives the CPU/RAM buffer enable (VBENn), the per-byte-lane chipset data buffer enables (DRDENn), the chipset data direction (DRDDIR) and the DMA latch enable (DMA_LATCH_EN). Enables are sequenced so that direction never changes while a buffer is driving, with a programmable turnaround gap. Agnus CAS strobes are synchronised to the system clock. The block sits in U712 between the cycle decode logic and the 74x245/74x646-class transceivers.

## Interface
Parameters:
- LANES, 2: number of chipset byte lanes (one CAS strobe and one DRDENn per lane).
- SYNC_STAGES, 2: synchroniser depth for the CASn inputs (≥2).
- TURN_CYC, 2: cycles with enables off after a buffer is released or a direction reversal is requested (0 is treated as 1).

Ports:
- CLK80  in  1  system clock; all state on rising edge.
- RESETn  in  1  reset, asynchronous and active-low.
- RnW  in  1  CPU read (1) / write (0).
- REG_CYCLE  in  1  CPU chip-register cycle active.
- CPU_CYCLE  in  1  CPU chip-RAM cycle active.
- WRITE_CYCLE  in  1  Agnus DMA write (1) / read (0).
- CASn  in  LANES  Agnus CAS strobes, asynchronous, active-low.
- VBENn  out  1  CPU-to-RAM/chipset buffer enable, active-low.
- DRDENn  out  LANES  chipset data buffer enables, active-low.
- DRDDIR  out  1  chipset buffer direction; 1 = REG write or DMA read.
- DMA_LATCH_EN  out  1  latch clock enable (SAB=1) during DMA read.
- VB_RDY  out  1  VB buffer is driving; CPU cycle may proceed.
- DRD_RDY  out  1  DRD buffer is driving in the requested direction.

## Operation
- dma_lane[i] = CASn[i] low after SYNC_STAGES flops. dma = OR of dma_lane.
- VB channel: req = REG_CYCLE | CPU_CYCLE. It has no direction; its dir_req is tied constant.
- DRD channel: req = dma | REG_CYCLE.
  - If REG_CYCLE is asserted: dir_req = !RnW and source = REG.
  - Otherwise: dir_req = !WRITE_CYCLE and source = DMA.
- Each channel runs the FSM below.
  - IDLE: enable off. On req, latch dir_req into dir and go to SETUP.
  - SETUP (1 cycle): dir is driven, enable still off. Then go to ON.
  - ON: enable on and RDY=1. Drop req, or dir_req≠dir, sends it to TURN.
  - TURN: enable off and dir held for max(TURN_CYC,1) cycles, then IDLE. A req present on exit re-enters SETUP on the next cycle via IDLE.
- DRDENn[i] in ON:
  - Source REG: all lanes low.
  - Source DMA: low only for lanes with dma_lane[i]=1. Lanes track CAS each cycle without leaving ON.
- Source switch REG↔DMA with the same dir stays in ON. A source switch with a different dir goes to TURN.
- DMA_LATCH_EN = DRD channel in ON & source DMA & dir=1 (DMA read). It is registered.
- Outputs change only on CLK80 edges. There are no combinational paths from inputs to outputs.

## Timing
- Reset values: VBENn=1, DRDENn=all 1, DRDDIR=0, DMA_LATCH_EN=0, VB_RDY=0, DRD_RDY=0. Counters are 0 and both FSMs are in IDLE.
- Latency from a synchronous req to enable low is 2 cycles (IDLE→SETUP→ON).
- Latency from a CAS fall to DRDENn low is SYNC_STAGES+2 cycles.
- Release: the enable goes high on the first edge after req drops, with dir unchanged in that cycle.
- Reversal: enable off for ≥max(TURN_CYC,1) cycles, then 1 SETUP cycle with the new DRDDIR, then enable. DRDDIR never changes in a cycle where any DRDENn is low.
- Simultaneous REG_CYCLE and dma: REG wins the direction. DMA lanes are covered because REG enables all lanes.
- A req that drops during SETUP goes to TURN, and the enable never asserts.
- RESETn low mid-cycle forces the reset values immediately (asynchronously), regardless of state.

## Structure
- A shared package u712_pkg holds the channel state enum (IDLE, SETUP, ON, TURN) and the direction constants DIR_TO_CHIP=1 and DIR_FROM_CHIP=0.
- One sub-module, u712_buf_channel, has parameters TURN_CYC and HAS_DIR. It has inputs req and dir_req, outputs en, dir and rdy, and owns the turnaround counter. It is instantiated twice (VB and DRD).
- The top level holds the CAS synchronisers, source and lane muxing, and the output registers.

## Test plan
- Reset: assert RESETn low mid-ON → all outputs at reset values within the same cycle. After release, 2 idle cycles show no enables.
- CPU_CYCLE=1 from idle → VBENn low on cycle 2 and VB_RDY=1. Drop CPU_CYCLE → VBENn high on the next edge.
- REG write (REG_CYCLE=1, RnW=0) → DRDDIR=1 at cycle 1 and DRDENn=2'b00 at cycle 2. Switch to RnW=1 → DRDENn=2'b11 for TURN_CYC=2 cycles, then 1 SETUP cycle with DRDDIR=0, then DRDENn=2'b00.
- DMA read on lane 0 only (CASn=2'b10, WRITE_CYCLE=0) → after 4 cycles DRDENn=2'b10, DRDDIR=1, DMA_LATCH_EN=1. CASn=2'b00 → DRDENn=2'b00 after 2 cycles without leaving ON.
- DMA write active when REG read arrives (dir 0→0) → stays in ON and DRDENn goes all low next cycle. With a REG write instead → TURN is inserted and DMA_LATCH_EN=0 throughout.
- TURN_CYC=0 build → the reversal gap is exactly 1 cycle. Scoreboard check: DRDDIR is never toggled while any enable is low.

Source files
------------

// File: rtl/u712_pkg.sv
// Shared types and constants for the U712 buffer sequencer.
package u712_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ON,
    TURN
  } chan_state_t;

  localparam logic DIR_TO_CHIP   = 1'b1;
  localparam logic DIR_FROM_CHIP = 1'b0;

endpackage

// File: rtl/u712_buf_channel.sv
// One buffer channel: sequences enable and direction with a setup cycle
// and a turnaround gap so direction never moves under a driving buffer.
module u712_buf_channel
  import u712_pkg::*;
#(
  parameter int unsigned TURN_CYC = 2,
  parameter bit          HAS_DIR  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic dir_req,
  output logic en,
  output logic dir,
  output logic rdy
);

  localparam int unsigned TURN_EFF = (TURN_CYC < 1) ? 1 : TURN_CYC;
  localparam int unsigned CW       = (TURN_EFF > 1) ? $clog2(TURN_EFF) : 1;
  localparam logic [CW-1:0] TURN_LOAD = CW'(TURN_EFF - 1);

  chan_state_t   state;
  logic [CW-1:0] cnt;
  logic          dir_sel;

  assign dir_sel = HAS_DIR ? dir_req : DIR_FROM_CHIP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      dir   <= DIR_FROM_CHIP;
      en    <= 1'b0;
      rdy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            dir   <= dir_sel;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (req && (dir_sel == dir)) begin
            state <= ON;
            en    <= 1'b1;
            rdy   <= 1'b1;
          end else begin
            state <= TURN;
            cnt   <= TURN_LOAD;
          end
        end
        ON: begin
          if (!req || (dir_sel != dir)) begin
            state <= TURN;
            cnt   <= TURN_LOAD;
            en    <= 1'b0;
            rdy   <= 1'b0;
          end
        end
        TURN: begin
          // A pending request skips the idle cycle and latches its direction on exit.
          if (cnt == '0) begin
            if (req) begin
              dir   <= dir_sel;
              state <= SETUP;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/u712_buffer_sequencer.sv
// U712 buffer control: CAS synchronisers, source/lane muxing and the
// VB and DRD channel sequencers.
module u712_buffer_sequencer
  import u712_pkg::*;
#(
  parameter int unsigned LANES       = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TURN_CYC    = 2
) (
  input  logic             CLK80,
  input  logic             RESETn,
  input  logic             RnW,
  input  logic             REG_CYCLE,
  input  logic             CPU_CYCLE,
  input  logic             WRITE_CYCLE,
  input  logic [LANES-1:0] CASn,
  output logic             VBENn,
  output logic [LANES-1:0] DRDENn,
  output logic             DRDDIR,
  output logic             DMA_LATCH_EN,
  output logic             VB_RDY,
  output logic             DRD_RDY
);

  logic [LANES-1:0] sync_q [SYNC_STAGES];
  logic [LANES-1:0] dma_lane;
  logic             dma;
  logic             src_reg_q;
  logic             drd_req;
  logic             drd_dir_req;
  logic             vb_en, vb_dir, vb_rdy;
  logic             drd_en, drd_dir, drd_rdy;
  logic             unused_vb_dir;

  assign dma_lane      = sync_q[SYNC_STAGES-1];
  assign dma           = |dma_lane;
  assign drd_req       = dma | REG_CYCLE;
  assign drd_dir_req   = REG_CYCLE ? ~RnW : ~WRITE_CYCLE;
  assign unused_vb_dir = vb_dir;

  // src_reg_q follows the same sample point as the channel state, so it
  // always describes the request that the current ON cycle is serving.
  always_ff @(posedge CLK80 or negedge RESETn) begin
    if (!RESETn) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      src_reg_q <= 1'b0;
    end else begin
      sync_q[0] <= ~CASn;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      src_reg_q <= REG_CYCLE;
    end
  end

  u712_buf_channel #(
    .TURN_CYC (TURN_CYC),
    .HAS_DIR  (1'b0)
  ) u_vb (
    .clk     (CLK80),
    .rst_n   (RESETn),
    .req     (REG_CYCLE | CPU_CYCLE),
    .dir_req (DIR_FROM_CHIP),
    .en      (vb_en),
    .dir     (vb_dir),
    .rdy     (vb_rdy)
  );

  u712_buf_channel #(
    .TURN_CYC (TURN_CYC),
    .HAS_DIR  (1'b1)
  ) u_drd (
    .clk     (CLK80),
    .rst_n   (RESETn),
    .req     (drd_req),
    .dir_req (drd_dir_req),
    .en      (drd_en),
    .dir     (drd_dir),
    .rdy     (drd_rdy)
  );

  assign VBENn        = ~vb_en;
  assign VB_RDY       = vb_rdy;
  assign DRDENn       = ~({LANES{drd_en}} & (src_reg_q ? {LANES{1'b1}} : dma_lane));
  assign DRDDIR       = drd_dir;
  assign DMA_LATCH_EN = drd_en & ~src_reg_q & (drd_dir == DIR_TO_CHIP);
  assign DRD_RDY      = drd_rdy;

endmodule

// File: tb/tb_u712_buffer_sequencer.sv
// Bench for u712_buffer_sequencer: directed scenarios plus randomized
// stimulus against a behavioural model, on TURN_CYC=2 and TURN_CYC=0 builds.
module tb_u712_buffer_sequencer;

  localparam int SYNC = 2;

  logic       CLK80       = 1'b0;
  logic       RESETn      = 1'b0;
  logic       RnW         = 1'b1;
  logic       REG_CYCLE   = 1'b0;
  logic       CPU_CYCLE   = 1'b0;
  logic       WRITE_CYCLE = 1'b0;
  logic [1:0] CASn        = 2'b11;

  logic       vben   [2];
  logic [1:0] drden  [2];
  logic       drddir [2];
  logic       latch  [2];
  logic       vbrdy  [2];
  logic       drdrdy [2];
  // {VBENn, VB_RDY, DRDENn[1:0], DRDDIR, DMA_LATCH_EN, DRD_RDY}
  logic [6:0] obs    [2];

  int tests = 0;
  int fails = 0;

  localparam logic [6:0] RST_VEC = 7'b1011000;

  always #5 CLK80 = ~CLK80;

  u712_buffer_sequencer #(.LANES(2), .SYNC_STAGES(SYNC), .TURN_CYC(2)) dut_a (
    .CLK80(CLK80), .RESETn(RESETn), .RnW(RnW), .REG_CYCLE(REG_CYCLE),
    .CPU_CYCLE(CPU_CYCLE), .WRITE_CYCLE(WRITE_CYCLE), .CASn(CASn),
    .VBENn(vben[0]), .DRDENn(drden[0]), .DRDDIR(drddir[0]),
    .DMA_LATCH_EN(latch[0]), .VB_RDY(vbrdy[0]), .DRD_RDY(drdrdy[0]));

  u712_buffer_sequencer #(.LANES(2), .SYNC_STAGES(SYNC), .TURN_CYC(0)) dut_b (
    .CLK80(CLK80), .RESETn(RESETn), .RnW(RnW), .REG_CYCLE(REG_CYCLE),
    .CPU_CYCLE(CPU_CYCLE), .WRITE_CYCLE(WRITE_CYCLE), .CASn(CASn),
    .VBENn(vben[1]), .DRDENn(drden[1]), .DRDDIR(drddir[1]),
    .DMA_LATCH_EN(latch[1]), .VB_RDY(vbrdy[1]), .DRD_RDY(drdrdy[1]));

  assign obs[0] = {vben[0], vbrdy[0], drden[0], drddir[0], latch[0], drdrdy[0]};
  assign obs[1] = {vben[1], vbrdy[1], drden[1], drddir[1], latch[1], drdrdy[1]};

  // Behavioural model: per build d, per channel c (0=VB, 1=DRD).
  bit       m_on    [2][2];
  bit       m_setup [2][2];
  bit       m_dir   [2][2];
  int       m_gap   [2][2];
  bit [1:0] hist    [SYNC];
  bit       src_q;
  bit       mreq;
  bit       mdreq;

  function automatic int gap_len(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic chan_step(input int d, input int c, input bit req, input bit dreq);
    if (m_gap[d][c] > 0) begin
      m_gap[d][c]--;
      if (m_gap[d][c] == 0 && req) begin
        m_dir[d][c]   = dreq;
        m_setup[d][c] = 1'b1;
      end
    end else if (m_setup[d][c]) begin
      m_setup[d][c] = 1'b0;
      if (req && dreq == m_dir[d][c]) m_on[d][c] = 1'b1;
      else m_gap[d][c] = gap_len(d);
    end else if (m_on[d][c]) begin
      if (!req || dreq != m_dir[d][c]) begin
        m_on[d][c]  = 1'b0;
        m_gap[d][c] = gap_len(d);
      end
    end else if (req) begin
      m_dir[d][c]   = dreq;
      m_setup[d][c] = 1'b1;
    end
  endtask

  always @(posedge CLK80 or negedge RESETn) begin
    if (!RESETn) begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < 2; c++) begin
          m_on[d][c] = 1'b0; m_setup[d][c] = 1'b0; m_dir[d][c] = 1'b0; m_gap[d][c] = 0;
        end
      for (int s = 0; s < SYNC; s++) hist[s] = 2'b00;
      src_q = 1'b0;
    end else begin
      mreq  = (|hist[SYNC-1]) | REG_CYCLE;
      mdreq = REG_CYCLE ? !RnW : !WRITE_CYCLE;
      for (int d = 0; d < 2; d++) begin
        chan_step(d, 0, REG_CYCLE | CPU_CYCLE, 1'b0);
        chan_step(d, 1, mreq, mdreq);
      end
      for (int s = SYNC - 1; s > 0; s--) hist[s] = hist[s-1];
      hist[0] = ~CASn;
      src_q   = REG_CYCLE;
    end
  end

  function automatic logic [6:0] exp_vec(input int d);
    logic [1:0] lanes_on;
    lanes_on = m_on[d][1] ? (src_q ? 2'b11 : hist[SYNC-1]) : 2'b00;
    return {!m_on[d][0], m_on[d][0], ~lanes_on, m_dir[d][1],
            m_on[d][1] && !src_q && m_dir[d][1], m_on[d][1]};
  endfunction

  task automatic quiesce();
    @(negedge CLK80);
    REG_CYCLE = 1'b0; CPU_CYCLE = 1'b0; RnW = 1'b1; WRITE_CYCLE = 1'b0; CASn = 2'b11;
    repeat (8) @(negedge CLK80);
    RESETn = 1'b0;
    @(negedge CLK80);
    RESETn = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (obs[d] !== RST_VEC) begin
        fails++; $display("FAIL reset_init d%0d got=%b exp=%b", d, obs[d], RST_VEC);
      end
    end
    @(negedge CLK80);
    RESETn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK80);
      tests++;
      if (obs[0] !== RST_VEC) begin
        fails++; $display("FAIL reset_idle%0d got=%b exp=%b", i, obs[0], RST_VEC);
      end
    end
    CPU_CYCLE = 1'b1; REG_CYCLE = 1'b1; RnW = 1'b0;
    repeat (2) @(posedge CLK80);
    #2;
    tests++;
    if ({obs[0][6], obs[0][4:3]} !== 3'b000) begin
      fails++; $display("FAIL reset_pre_on got=%b exp=000", {obs[0][6], obs[0][4:3]});
    end
    RESETn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (obs[d] !== RST_VEC) begin
        fails++; $display("FAIL reset_async d%0d got=%b exp=%b", d, obs[d], RST_VEC);
      end
    end
    @(negedge CLK80);
    CPU_CYCLE = 1'b0; REG_CYCLE = 1'b0; RnW = 1'b1;
    RESETn = 1'b1;
  endtask

  task automatic test_vb();
    logic [1:0] e;
    quiesce();
    @(negedge CLK80);
    CPU_CYCLE = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK80);
      e = (c == 1) ? 2'b10 : 2'b01;
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (obs[d][6:5] !== e) begin
          fails++; $display("FAIL vb_on d%0d c%0d got=%b exp=%b", d, c, obs[d][6:5], e);
        end
      end
    end
    tests++;
    if (obs[0][4:0] !== 5'b11000) begin
      fails++; $display("FAIL vb_drd_idle got=%b exp=11000", obs[0][4:0]);
    end
    CPU_CYCLE = 1'b0;
    @(negedge CLK80);
    tests++;
    if (obs[0][6:5] !== 2'b10) begin
      fails++; $display("FAIL vb_release got=%b exp=10", obs[0][6:5]);
    end
  endtask

  task automatic test_reg_reversal();
    logic [4:0] ea [6];
    logic [4:0] eb [6];
    ea = '{5'b11100, 5'b00101, 5'b11100, 5'b11100, 5'b11000, 5'b00001};
    eb = '{5'b11100, 5'b00101, 5'b11100, 5'b11000, 5'b00001, 5'b00001};
    quiesce();
    @(negedge CLK80);
    REG_CYCLE = 1'b1; RnW = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK80);
      tests++;
      if (obs[0][4:0] !== ea[i]) begin
        fails++; $display("FAIL reg_rev_t2 c%0d got=%b exp=%b", i + 1, obs[0][4:0], ea[i]);
      end
      tests++;
      if (obs[1][4:0] !== eb[i]) begin
        fails++; $display("FAIL reg_rev_t0 c%0d got=%b exp=%b", i + 1, obs[1][4:0], eb[i]);
      end
      if (i == 1) RnW = 1'b1;
    end
  endtask

  task automatic test_dma_lanes();
    logic [4:0] e [6];
    e = '{5'b11000, 5'b11000, 5'b11100, 5'b10111, 5'b10111, 5'b00111};
    quiesce();
    @(negedge CLK80);
    CASn = 2'b10; WRITE_CYCLE = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK80);
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (obs[d][4:0] !== e[i]) begin
          fails++; $display("FAIL dma_lanes d%0d c%0d got=%b exp=%b", d, i + 1, obs[d][4:0], e[i]);
        end
      end
      if (i == 3) CASn = 2'b00;
    end
  endtask

  task automatic test_source_switch();
    logic [4:0] ea [10];
    logic [4:0] eb [10];
    ea = '{5'b11000, 5'b11000, 5'b11000, 5'b01001, 5'b00001,
           5'b01001, 5'b11000, 5'b11000, 5'b11100, 5'b00101};
    eb = '{5'b11000, 5'b11000, 5'b11000, 5'b01001, 5'b00001,
           5'b01001, 5'b11000, 5'b11100, 5'b00101, 5'b00101};
    quiesce();
    @(negedge CLK80);
    CASn = 2'b01; WRITE_CYCLE = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK80);
      tests++;
      if (obs[0][4:0] !== ea[i]) begin
        fails++; $display("FAIL src_switch_t2 c%0d got=%b exp=%b", i + 1, obs[0][4:0], ea[i]);
      end
      tests++;
      if (obs[1][4:0] !== eb[i]) begin
        fails++; $display("FAIL src_switch_t0 c%0d got=%b exp=%b", i + 1, obs[1][4:0], eb[i]);
      end
      case (i)
        3: begin REG_CYCLE = 1'b1; RnW = 1'b1; end
        4: REG_CYCLE = 1'b0;
        5: begin REG_CYCLE = 1'b1; RnW = 1'b0; end
        default: ;
      endcase
    end
  endtask

  task automatic test_random();
    logic [1:0] prev_en [2];
    logic       prev_dir [2];
    bit         prev_ok;
    logic [6:0] e;
    quiesce();
    prev_ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge CLK80);
      for (int d = 0; d < 2; d++) begin
        e = exp_vec(d);
        tests++;
        if (obs[d] !== e) begin
          fails++; $display("FAIL random d%0d cyc%0d got=%b exp=%b", d, i, obs[d], e);
        end
        if (RESETn && prev_ok && drddir[d] !== prev_dir[d]) begin
          tests++;
          if (prev_en[d] !== 2'b11 || drden[d] !== 2'b11) begin
            fails++;
            $display("FAIL dir_toggle d%0d cyc%0d drden_before=%b drden_after=%b exp=11",
                     d, i, prev_en[d], drden[d]);
          end
        end
        prev_en[d]  = drden[d];
        prev_dir[d] = drddir[d];
      end
      prev_ok = RESETn;
      if (!RESETn) RESETn = 1'b1;
      else if ($urandom_range(149) == 0) RESETn = 1'b0;
      if ($urandom_range(3) == 0) REG_CYCLE   = ~REG_CYCLE;
      if ($urandom_range(3) == 0) CPU_CYCLE   = ~CPU_CYCLE;
      if ($urandom_range(3) == 0) RnW         = ~RnW;
      if ($urandom_range(5) == 0) WRITE_CYCLE = ~WRITE_CYCLE;
      if ($urandom_range(3) == 0) CASn[0]     = ~CASn[0];
      if ($urandom_range(3) == 0) CASn[1]     = ~CASn[1];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vb();
    test_reg_reversal();
    test_dma_lanes();
    test_source_switch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
